poly_voice_engine: RTL

Polyphonic successor to the single-tone piano path: scans a parametrised key bank, allocates up to NUM_VOICES simultaneous voices, fetches each voice's divider from the existing registered note_lut, and generates one square wave per voice plus a mixed PWM output. Sits between the pad inputs and uo_out in the piano top and replaces the single priority decoder and tone_gen pair.

---
 rtl/poly_voice_engine.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/poly_voice_engine.sv
// Polyphonic key scanner and voice allocator: per-voice square waves plus PWM mix.
// Optional build macro VOICE_STEAL_EN: reassign the oldest voice when none is free.
module poly_voice_engine #(
  parameter int NUM_KEYS   = 12,
  parameter int NUM_VOICES = 4,
  parameter int DIV_WIDTH  = 16,
  parameter int AGE_WIDTH  = 8
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  ena,
  input  logic [NUM_KEYS-1:0]                   keys,
  input  logic [3:0]                            octave,
  output logic [3:0]                            lut_note,
  output logic [3:0]                            lut_octave,
  input  logic [DIV_WIDTH-1:0]                  lut_div,
  output logic [NUM_VOICES-1:0]                 tone_out,
  output logic [$clog2(NUM_VOICES+1)-1:0]       mix,
  output logic                                  pwm_out,
  output logic [NUM_VOICES-1:0]                 voice_busy
);

  localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int MW = $clog2(NUM_VOICES + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WAIT, S_ASSIGN} state_t;

  state_t                state, state_d;
  logic [NUM_KEYS-1:0]   held, ignored, owned, need;
  logic [KW-1:0]         key_q, pick;
  logic                  pick_vld;
  logic [NUM_VOICES-1:0] active, tone, rel;
  logic [KW-1:0]         owner [NUM_VOICES];
  logic [DIV_WIDTH-1:0]  div   [NUM_VOICES];
  logic [DIV_WIDTH-1:0]  cnt   [NUM_VOICES];
  logic [VW-1:0]         free_idx, asg_idx;
  logic                  free_vld, asg_en, drop, latch;
  logic [MW-1:0]         mix_q, pwm_cnt, pop;
  logic                  pwm_q;
  logic [4:0]            oct_sum;

  always_comb begin
    owned = '0;
    rel   = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++)
      for (int unsigned k = 0; k < NUM_KEYS; k++)
        if (active[v] && owner[v] == KW'(k)) begin
          owned[k] = 1'b1;
          rel[v]   = ~held[k];
        end
  end

  assign need = held & ~owned & ~ignored;

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned k = 0; k < NUM_KEYS; k++)
      if (need[k] && !pick_vld) begin
        pick     = KW'(k);
        pick_vld = 1'b1;
      end
  end

  always_comb begin
    free_idx = '0;
    free_vld = 1'b0;
    for (int unsigned v = 0; v < NUM_VOICES; v++)
      if (!active[v] && !free_vld) begin
        free_idx = VW'(v);
        free_vld = 1'b1;
      end
  end

`ifdef VOICE_STEAL_EN
  logic [AGE_WIDTH-1:0] age [NUM_VOICES];
  logic [AGE_WIDTH-1:0] best_age;
  logic [VW-1:0]        old_idx;

  // strict compare keeps the lowest index on an age tie
  always_comb begin
    best_age = age[0];
    old_idx  = '0;
    for (int unsigned v = 1; v < NUM_VOICES; v++)
      if (age[v] > best_age) begin
        best_age = age[v];
        old_idx  = VW'(v);
      end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) age[v] <= '0;
    end else begin
      for (int unsigned v = 0; v < NUM_VOICES; v++)
        if (!rel[v] && asg_en && asg_idx == VW'(v)) age[v] <= '0;
        else if (active[v] && age[v] != '1) age[v] <= age[v] + AGE_WIDTH'(1);
    end
  end
`endif

  assign oct_sum = 5'(octave) + 5'(32'(pick) / 12);

  // lut_div is written straight into the voice at the end of WAIT, so the
  // voice is already busy while the FSM sits in ASSIGN.
  always_comb begin
    state_d = state;
    latch   = 1'b0;
    asg_en  = 1'b0;
    asg_idx = free_idx;
    drop    = 1'b0;
    case (state)
      S_IDLE:   if (pick_vld) begin
                  latch   = 1'b1;
                  state_d = S_LOOKUP;
                end
      S_LOOKUP: state_d = S_WAIT;
      S_WAIT: begin
        state_d = S_ASSIGN;
        if (held[key_q]) begin
          if (free_vld) asg_en = 1'b1;
          else begin
`ifdef VOICE_STEAL_EN
            asg_en  = 1'b1;
            asg_idx = old_idx;
`else
            drop    = 1'b1;
`endif
          end
        end
      end
      S_ASSIGN: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (!ena) begin
      state_d = S_IDLE;
      latch   = 1'b0;
      asg_en  = 1'b0;
      drop    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      held       <= '0;
      ignored    <= '0;
      key_q      <= '0;
      lut_note   <= '0;
      lut_octave <= '0;
    end else begin
      state <= state_d;
      held  <= keys;
      for (int unsigned k = 0; k < NUM_KEYS; k++)
        ignored[k] <= (ignored[k] & held[k]) | (drop && key_q == KW'(k));
      if (latch) begin
        key_q      <= pick;
        lut_note   <= 4'(32'(pick) % 12);
        lut_octave <= (oct_sum > 5'd15) ? 4'd15 : oct_sum[3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active <= '0;
      tone   <= '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        owner[v] <= '0;
        div[v]   <= '0;
        cnt[v]   <= '0;
      end
    end else begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (rel[v]) begin
          active[v] <= 1'b0;
          tone[v]   <= 1'b0;
          cnt[v]    <= '0;
        end else if (asg_en && asg_idx == VW'(v)) begin
          active[v] <= 1'b1;
          owner[v]  <= key_q;
          div[v]    <= lut_div;
          cnt[v]    <= '0;
          tone[v]   <= 1'b0;
        end else if (active[v]) begin
          if (div[v] == '0) begin
            cnt[v]  <= '0;
            tone[v] <= 1'b0;
          end else if (cnt[v] == div[v] - DIV_WIDTH'(1)) begin
            cnt[v]  <= '0;
            tone[v] <= ~tone[v];
          end else begin
            cnt[v]  <= cnt[v] + DIV_WIDTH'(1);
          end
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) pop = pop + MW'(tone_out[v]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mix_q   <= '0;
      pwm_cnt <= '0;
      pwm_q   <= 1'b0;
    end else begin
      mix_q   <= pop;
      pwm_cnt <= (pwm_cnt == MW'(NUM_VOICES - 1)) ? '0 : pwm_cnt + MW'(1);
      pwm_q   <= (pwm_cnt < mix_q);
    end
  end

  assign tone_out   = ena ? tone : '0;
  assign mix        = ena ? mix_q : '0;
  assign pwm_out    = ena & pwm_q;
  assign voice_busy = active;

endmodule
